pooling_job_scheduler: RTL and testbench

//  Sequences embedding-bag pooling jobs from NUM_REQ requesters onto the single process-core instruction port.

---
 rtl/pooling_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/pooling_job_scheduler.sv | 148 ++++++++++++++
 tb/tb_pooling_job_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_sched_pkg.sv
// Shared types for the pooling job scheduler: process-core opcodes, FSM states, instruction layout.
package pooling_sched_pkg;
    localparam logic [3:0] OP_READ_MEM   = 4'b0001;
    localparam logic [3:0] OP_WRITE_SWAP = 4'b0010;
    localparam logic [3:0] OP_ACCUM      = 4'b0011;
    localparam int         SLOT_W        = 4;
    localparam int         INSTR_ADDR_W  = 44;

    typedef enum logic [2:0] {IDLE, ARB, RD, ACC, SWP} sched_state_t;

    typedef struct packed {
        logic [3:0]              opcode;
        logic [INSTR_ADDR_W-1:0] addr;
        logic [15:0]             data;
    } instr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);
    int j;

    // Scan from lowest to highest priority so the last hit (closest to ptr) wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[IDX_W'(j)]) begin
                grant             = '0;
                grant[IDX_W'(j)]  = 1'b1;
                idx               = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/pooling_job_scheduler.sv
// Sequences embedding-bag pooling jobs onto the process-core instruction port and owns sum slots.
// Optional SCHED_PERF_CNT_EN adds accepted-instruction and stall counters.
module pooling_job_scheduler
    import pooling_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 16,
    parameter int LEN_W     = 8,
    parameter int ADDR_W    = 44
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic                      instr_valid,
    output logic [63:0]               instr,
    input  logic                      core_bp,
    input  logic                      slot_release,
    input  logic [3:0]                slot_rel_id,
    output logic                      done_valid,
    output logic [2:0]                done_req_id,
    output logic [3:0]                done_slot,
    output logic [NUM_SLOTS-1:0]      slots_free,
    output logic                      busy
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]               perf_instr_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);

    sched_state_t         state, state_d;
    logic [PTR_W-1:0]     rr_ptr, gnt_idx, job_id;
    logic [NUM_REQ-1:0]   gnt;
    logic [ADDR_W-1:0]    base_addr, sel_addr, row_addr;
    logic [LEN_W-1:0]     job_len, sel_len, row_k;
    logic [SLOT_W-1:0]    job_slot, alloc_slot;
    logic [NUM_SLOTS-1:0] alloc_mask, rel_mask;
    logic                 grant_fire, accept, last_row;
    instr_t               instr_s;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(PTR_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    assign sel_addr    = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_len     = req_len[int'(gnt_idx)*LEN_W +: LEN_W];
    assign grant_fire  = (state == ARB) && (|gnt);
    assign req_ready   = grant_fire ? gnt : '0;
    assign instr_valid = (state == RD) || (state == ACC) || (state == SWP);
    assign accept      = instr_valid && !core_bp;
    assign busy        = (state != IDLE);
    assign row_addr    = base_addr + ADDR_W'(row_k);
    assign last_row    = ({1'b0, row_k} + (LEN_W+1)'(1)) >= {1'b0, job_len};
    assign instr       = instr_s;

    // Lowest-index free slot.
    always_comb begin
        alloc_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (slots_free[i]) alloc_slot = SLOT_W'(i);
    end

    // Release is judged against the pre-update bitmap, so a slot freed this cycle is not reallocated.
    always_comb begin
        alloc_mask = '0;
        rel_mask   = '0;
        if (grant_fire) alloc_mask[alloc_slot] = 1'b1;
        if (slot_release && !slots_free[slot_rel_id]) rel_mask[slot_rel_id] = 1'b1;
    end

    always_comb begin
        state_d = state;
        instr_s = '0;
        case (state)
            IDLE: if ((|req_valid) && (|slots_free)) state_d = ARB;
            ARB: begin
                if (|gnt) state_d = (sel_len != '0) ? RD : SWP;
                else      state_d = IDLE;
            end
            RD: begin
                instr_s = '{opcode: OP_READ_MEM, addr: INSTR_ADDR_W'(row_addr), data: 16'h0};
                if (!core_bp) state_d = ACC;
            end
            ACC: begin
                instr_s = '{opcode: OP_ACCUM, addr: '0, data: 16'(job_slot)};
                if (!core_bp) state_d = last_row ? SWP : RD;
            end
            SWP: begin
                instr_s = '{opcode: OP_WRITE_SWAP, addr: '0, data: 16'(job_slot)};
                if (!core_bp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            slots_free  <= '1;
            base_addr   <= '0;
            job_len     <= '0;
            job_slot    <= '0;
            job_id      <= '0;
            row_k       <= '0;
            done_valid  <= 1'b0;
            done_req_id <= '0;
            done_slot   <= '0;
        end else begin
            state      <= state_d;
            slots_free <= (slots_free & ~alloc_mask) | rel_mask;
            done_valid <= 1'b0;
            if (grant_fire) begin
                base_addr <= sel_addr;
                job_len   <= sel_len;
                job_slot  <= alloc_slot;
                job_id    <= gnt_idx;
                row_k     <= '0;
                rr_ptr    <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
            if (state == ACC && !core_bp) row_k <= row_k + LEN_W'(1);
            if (state == SWP && !core_bp) begin
                done_valid  <= 1'b1;
                done_req_id <= 3'(job_id);
                done_slot   <= job_slot;
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_instr_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept)                  perf_instr_cnt <= perf_instr_cnt + 32'd1;
            if (instr_valid && core_bp)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pooling_job_scheduler.sv
// Self-checking bench for pooling_job_scheduler: job-level reference model plus directed and random tests.
module tb_pooling_job_scheduler;
    localparam int NR = 4, NS = 16, LW = 8, AW = 44;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic              instr_valid;
    logic [63:0]       instr;
    logic              core_bp, slot_release;
    logic [3:0]        slot_rel_id;
    logic              done_valid;
    logic [2:0]        done_req_id;
    logic [3:0]        done_slot;
    logic [NS-1:0]     slots_free;
    logic              busy;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]       perf_instr_cnt, perf_stall_cnt;
`endif

    pooling_job_scheduler #(.NUM_REQ(NR), .NUM_SLOTS(NS), .LEN_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .instr_valid(instr_valid), .instr(instr),
        .core_bp(core_bp), .slot_release(slot_release), .slot_rel_id(slot_rel_id),
        .done_valid(done_valid), .done_req_id(done_req_id), .done_slot(done_slot),
        .slots_free(slots_free), .busy(busy)
`ifdef SCHED_PERF_CNT_EN
        , .perf_instr_cnt(perf_instr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {int id; int slot;} done_t;
    typedef struct {int r; logic [AW-1:0] addr; int len; bit rel; int exp_slot; int exp_lat;} vec_t;

    int            checks = 0, errors = 0;
    logic [NS-1:0] m_free;
    int            m_ptr;
    logic [63:0]   exp_instr[$];
    done_t         exp_done[$];
    int            grant_log[$];
    int            cyc = 0, n_acc = 0, n_done = 0, n_grant = 0;
    int            last_grant_cyc = 0, last_done_cyc = 0, last_done_slot = 0, last_done_id = 0;
    bit            prev_ready = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int rr_pick(logic [NR-1:0] v, int p);
        int j;
        for (int i = 0; i < NR; i++) begin
            j = (p + i) % NR;
            if (v[2'(j)]) return j;
        end
        return -1;
    endfunction

    function automatic int low_free(logic [NS-1:0] f);
        for (int i = 0; i < NS; i++)
            if (f[4'(i)]) return i;
        return -1;
    endfunction

    // A granted job expands into its full instruction stream and completion record.
    task automatic model_grant(int g);
        logic [AW-1:0] a;
        int l, s;
        a = req_addr[g*AW +: AW];
        l = int'(req_len[g*LW +: LW]);
        s = low_free(m_free);
        if (s < 0) begin
            flag("grant_with_no_free_slot");
            return;
        end
        for (int k = 0; k < l; k++) begin
            exp_instr.push_back({4'b0001, a + AW'(k), 16'h0});
            exp_instr.push_back({4'b0011, 44'h0, 12'h0, 4'(s)});
        end
        exp_instr.push_back({4'b0010, 44'h0, 12'h0, 4'(s)});
        exp_done.push_back('{g, s});
        m_free[4'(s)] = 1'b0;
        m_ptr = (g + 1) % NR;
    endtask

    task automatic step();
        logic [NS-1:0] pre;
        logic [NR-1:0] gmask;
        int            g;
        bit            rel_hit;
        done_t         d;
        @(negedge clk);
        cyc++;
        pre = m_free;
        chk("slots_free", slots_free, m_free);
        if (prev_ready) chk("ready_to_instr_valid", instr_valid, 1);
        if (instr_valid && !core_bp) begin
            n_acc++;
            if (exp_instr.size() == 0) flag("unexpected_instr");
            else chk("instr", instr, exp_instr.pop_front());
        end
        if (done_valid) begin
            n_done++;
            last_done_cyc  = cyc;
            last_done_slot = int'(done_slot);
            last_done_id   = int'(done_req_id);
            if (exp_done.size() == 0) flag("unexpected_done");
            else begin
                d = exp_done.pop_front();
                chk("done_req_id", done_req_id, d.id);
                chk("done_slot", done_slot, d.slot);
            end
        end
        rel_hit    = slot_release && !pre[slot_rel_id];
        gmask      = req_ready;
        prev_ready = (req_ready != '0);
        if (req_ready != '0) begin
            g = rr_pick(req_valid, m_ptr);
            if (g < 0) flag("ready_without_request");
            else begin
                chk("grant", req_ready, 64'(1) << g);
                model_grant(g);
                grant_log.push_back(g);
                n_grant++;
                last_grant_cyc = cyc;
            end
        end
        if (rel_hit) m_free[slot_rel_id] = 1'b1;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~gmask;
    endtask

    task automatic set_req(int r, logic [AW-1:0] a, int l);
        req_valid[2'(r)]       = 1'b1;
        req_addr[r*AW +: AW]   = a;
        req_len[r*LW +: LW]    = LW'(l);
    endtask

    task automatic wait_done(int budget);
        int n0 = n_done;
        int t = 0;
        while (n_done == n0 && t < budget) begin step(); t++; end
        if (n_done == n0) flag("done_timeout");
    endtask

    task automatic wait_grants(int n, int budget);
        int n0 = n_grant;
        int t = 0;
        while (n_grant < n0 + n && t < budget) begin step(); t++; end
        if (n_grant < n0 + n) flag("grant_timeout");
    endtask

    task automatic wait_idle(int budget);
        int t = 0;
        while ((busy || exp_instr.size() != 0 || exp_done.size() != 0) && t < budget) begin step(); t++; end
        if (busy || exp_instr.size() != 0 || exp_done.size() != 0) flag("idle_timeout");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0;
        core_bp = 1'b0; slot_release = 1'b0; slot_rel_id = '0;
        m_free = '1; m_ptr = 0; prev_ready = 0; n_acc = 0;
        exp_instr.delete(); exp_done.delete(); grant_log.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    vec_t        tbl[5];
    int          rr_exp[6];
    logic [63:0] exp_r1, rv;
    logic [AW-1:0] ra;
    int          g0, t;

    initial begin
        tbl[0] = '{0, 44'h100,          2, 1'b0, 0, 6};
        tbl[1] = '{2, 44'h2000,         0, 1'b0, 1, 2};
        tbl[2] = '{1, 44'hFFF_FFFF_FFFF, 2, 1'b1, 2, 6};
        tbl[3] = '{3, 44'h55,           1, 1'b0, 2, 4};
        tbl[4] = '{0, 44'h7,            3, 1'b0, 3, 8};
        rr_exp = '{0, 1, 3, 0, 2, 3};

        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0;
        core_bp = 1'b0; slot_release = 1'b0; slot_rel_id = '0;
        #2;
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_req_id", done_req_id, 0);
        chk("rst_done_slot", done_slot, 0);
        chk("rst_slots_free", slots_free, 16'hFFFF);
        chk("rst_busy", busy, 0);

        // Table: single jobs, slot allocation, latency, empty bag, address wrap, release reuse.
        do_reset();
        foreach (tbl[i]) begin
            set_req(tbl[i].r, tbl[i].addr, tbl[i].len);
            wait_done(40);
            chk("tbl_done_id", last_done_id, tbl[i].r);
            chk("tbl_done_slot", last_done_slot, tbl[i].exp_slot);
            chk("tbl_latency", last_done_cyc - last_grant_cyc, tbl[i].exp_lat);
            if (tbl[i].rel) begin
                slot_release = 1'b1;
                slot_rel_id  = 4'(tbl[i].exp_slot);
                step();
                slot_release = 1'b0;
            end
            step();
        end

        // Round-robin rotation.
        do_reset();
        set_req(0, 44'h10, 1);
        wait_grants(1, 10);
        set_req(1, 44'h20, 1);
        set_req(3, 44'h30, 1);
        set_req(0, 44'h40, 1);
        wait_grants(3, 60);
        set_req(2, 44'h50, 1);
        set_req(3, 44'h60, 1);
        wait_grants(2, 60);
        wait_idle(40);
        chk("rr_count", grant_log.size(), 6);
        foreach (rr_exp[i])
            if (i < grant_log.size()) chk("rr_order", grant_log[i], rr_exp[i]);

        // Backpressure during the second read.
        do_reset();
        set_req(0, 44'h40, 2);
        t = 0;
        while (exp_instr.size() != 3 && t < 20) begin step(); t++; end
        exp_r1 = {4'b0001, 44'h41, 16'h0};
        chk("t3_rd_row1", instr, exp_r1);
        core_bp = 1'b1;
        repeat (5) begin
            step();
            chk("t3_hold_instr", instr, exp_r1);
            chk("t3_hold_valid", instr_valid, 1);
        end
        core_bp = 1'b0;
        wait_done(30);
        chk("t3_latency", last_done_cyc - last_grant_cyc, 11);
`ifdef SCHED_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, 5);
        chk("perf_instr_cnt", perf_instr_cnt, 5);
`endif

        // Slot exhaustion, then reuse of a released slot.
        do_reset();
        for (int i = 0; i < NS; i++) begin
            set_req(0, AW'(i * 16), 1);
            wait_done(20);
            chk("t4_slot", last_done_slot, i);
        end
        set_req(1, 44'h999, 1);
        g0 = n_grant;
        repeat (20) step();
        chk("t4_no_grant_when_full", n_grant - g0, 0);
        chk("t4_idle_when_full", busy, 0);
        slot_release = 1'b1;
        slot_rel_id  = 4'd7;
        step();
        slot_release = 1'b0;
        wait_done(20);
        chk("t4_reuse_slot7", last_done_slot, 7);
        chk("t4_reuse_id", last_done_id, 1);

        // Release in the allocation cycle: allocation sees the pre-release bitmap.
        do_reset();
        set_req(0, 44'h5, 0);
        wait_done(20);
        set_req(1, 44'h6, 0);
        step();
        slot_release = 1'b1;
        slot_rel_id  = 4'd0;
        step();
        slot_release = 1'b0;
        chk("t7_grant_in_release_cycle", last_grant_cyc, cyc);
        wait_done(20);
        chk("t7_alloc_pre_release", last_done_slot, 1);
        step();
        chk("t7_bitmap", slots_free, 16'hFFFD);

        // Reset in the middle of an accumulate.
        do_reset();
        set_req(0, 44'h300, 3);
        t = 0;
        while (!(instr_valid && instr[63:60] == 4'b0011) && t < 20) begin step(); t++; end
        if (t >= 20) flag("t6_acc_timeout");
        reset = 1'b1;
        #1;
        chk("t6_instr_valid", instr_valid, 0);
        chk("t6_instr", instr, 0);
        chk("t6_busy", busy, 0);
        chk("t6_slots_free", slots_free, 16'hFFFF);
        chk("t6_req_ready", req_ready, 0);
        do_reset();
        set_req(2, 44'h400, 1);
        wait_done(20);
        chk("t6_slot_after_reset", last_done_slot, 0);
        chk("t6_id_after_reset", last_done_id, 2);

        // Random traffic against the job-level model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[2'(r)] && $urandom_range(0, 5) == 0) begin
                    rv = {$urandom, $urandom};
                    ra = rv[AW-1:0];
                    if ($urandom_range(0, 3) == 0) ra = {AW{1'b1}} - AW'($urandom_range(0, 2));
                    set_req(r, ra, int'($urandom_range(0, 3)));
                end
            end
            core_bp      = ($urandom_range(0, 3) == 0);
            slot_release = ($urandom_range(0, 2) == 0);
            slot_rel_id  = 4'($urandom_range(0, 15));
            step();
        end
        core_bp = 1'b0;
        t = 0;
        while ((req_valid != '0 || busy || exp_instr.size() != 0 || exp_done.size() != 0) && t < 3000) begin
            slot_release = 1'b1;
            slot_rel_id  = 4'($urandom_range(0, 15));
            step();
            t++;
        end
        slot_release = 1'b0;
        if (t >= 3000) flag("drain_timeout");
        chk("rand_instr_queue_empty", exp_instr.size(), 0);
        chk("rand_done_queue_empty", exp_done.size(), 0);
`ifdef SCHED_PERF_CNT_EN
        chk("rand_perf_instr_cnt", perf_instr_cnt, n_acc);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
